instruction_sequencer: RTL

Multi-cycle control FSM for the single-issue RV32I core. It owns the program counter and instruction register, fetches and holds each instruction, and sequences the decoded op through the shared ALU datapath. It drives the data memory handshake for loads and stores, resolves branches and jumps from the ALU outputs, and issues register-file writeback. It sits between the instruction/data memory ports, the instruction decoder, the ALU wiring block and the register file.

---
 rtl/instruction_sequencer_pkg.sv | 55 +++++
 rtl/next_pc_unit.sv | 59 +++++
 rtl/instruction_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/instruction_sequencer_pkg.sv
// Shared core package for the multi-cycle RV32I control path.
//   InstructionSet : one-hot decoded op word produced by the instruction
//                    decoder (one field per RV32I op, MSB first).
//   SeqState       : sequencer FSM states.
//   PC_STEP        : byte distance between sequential instructions.
package instruction_sequencer_pkg;

   // Instruction constants shared with the decoder. At most one field is set.
   // All fields clear means the word did not decode to a legal op.
   typedef struct packed {
      logic lui;
      logic auipc;
      logic jal;
      logic jalr;
      logic beq;
      logic bne;
      logic blt;
      logic bge;
      logic bltu;
      logic bgeu;
      logic lw;
      logic sw;
      logic addi;
      logic slti;
      logic sltiu;
      logic xori;
      logic ori;
      logic andi;
      logic slli;
      logic srli;
      logic srai;
      logic add;
      logic sub;
      logic sll;
      logic slt;
      logic sltu;
      logic xor_op;
      logic srl;
      logic sra;
      logic or_op;
      logic and_op;
   } InstructionSet;

   typedef enum logic [2:0] {
      FETCH     = 3'd0,
      DECODE    = 3'd1,
      EXECUTE   = 3'd2,
      MEMORY    = 3'd3,
      WRITEBACK = 3'd4,
      HALT      = 3'd5
   } SeqState;

   localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/next_pc_unit.sv
// Combinational op classification and control-flow resolution.
//   op        : one-hot decoded op
//   pc        : address of the current instruction
//   alu_out   : ALU primary result (branch/jump target or memory address)
//   alu_out_b : ALU compare result (EQ / LT / LTU depending on the branch)
//   op_legal  : at least one op bit is set
//   is_branch, is_load, is_store, is_mem, is_link : op class flags
//   pc_plus4  : pc + 4, 32-bit wrap
//   next_pc   : address of the following instruction
//   fault     : misaligned next_pc, or misaligned LW/SW address
module next_pc_unit
   import instruction_sequencer_pkg::*;
(
   input  InstructionSet op,
   input  logic [31:0]   pc,
   input  logic [31:0]   alu_out,
   input  logic          alu_out_b,
   output logic          op_legal,
   output logic          is_branch,
   output logic          is_load,
   output logic          is_store,
   output logic          is_mem,
   output logic          is_link,
   output logic [31:0]   pc_plus4,
   output logic [31:0]   next_pc,
   output logic          fault
);

   logic take_on_set;
   logic take_on_clear;
   logic taken;

   always_comb begin
      op_legal  = (op != '0);
      is_load   = op.lw;
      is_store  = op.sw;
      is_mem    = op.lw | op.sw;
      is_link   = op.jal | op.jalr;
      is_branch = op.beq | op.bne | op.blt | op.bge | op.bltu | op.bgeu;

      // BNE/BGE/BGEU reuse the same compare as BEQ/BLT/BLTU with the
      // sense inverted.
      take_on_set   = op.beq | op.blt | op.bltu;
      take_on_clear = op.bne | op.bge | op.bgeu;
      taken         = (take_on_set & alu_out_b) | (take_on_clear & ~alu_out_b);

      pc_plus4 = pc + PC_STEP;
      next_pc  = pc_plus4;
      if (taken || op.jal) begin
         next_pc = alu_out;
      end
      if (op.jalr) begin
         next_pc = {alu_out[31:1], 1'b0};
      end

      fault = (next_pc[1:0] != 2'b00) | (is_mem & (alu_out[1:0] != 2'b00));
   end

endmodule

// File: rtl/instruction_sequencer.sv
// Multi-cycle control FSM of the single-issue RV32I core. Owns pc and the
// instruction register, steps each op through FETCH, DECODE, EXECUTE,
// (MEMORY), WRITEBACK, and stops in HALT on an illegal op or a fault.
//   clk, reset                 : clock, synchronous active-high reset
//   imem_req/addr/ready/rdata  : instruction fetch port
//   instr, op                  : instruction register out, decoded op in
//   pc, alu_out, alu_out_b     : pc to ALU wiring, ALU results back
//   reg2                       : rs2 value, used as store data
//   dmem_req/we/addr/wdata/ready/rdata : data memory port
//   rf_we, rf_wdata            : register-file writeback
//   retire                     : one pulse per completed instruction
//   halted                     : sticky fault flag, cleared by reset
//   state_dbg                  : current FSM state
//
// Handshake: a request (imem_req / dmem_req) is a Moore output that stays
// high with a stable address until the cycle where req && ready, which is
// the single transfer cycle; read data is sampled in that same cycle.
module instruction_sequencer
   import instruction_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          reset,
   output logic          imem_req,
   output logic [31:0]   imem_addr,
   input  logic          imem_ready,
   input  logic [31:0]   imem_rdata,
   output logic [31:0]   instr,
   input  InstructionSet op,
   output logic [31:0]   pc,
   input  logic [31:0]   alu_out,
   input  logic          alu_out_b,
   input  logic [31:0]   reg2,
   output logic          dmem_req,
   output logic          dmem_we,
   output logic [31:0]   dmem_addr,
   output logic [31:0]   dmem_wdata,
   input  logic          dmem_ready,
   input  logic [31:0]   dmem_rdata,
   output logic          rf_we,
   output logic [31:0]   rf_wdata,
   output logic          retire,
   output logic          halted,
   output SeqState       state_dbg
);

   SeqState     state;
   SeqState     state_next;
   logic [31:0] result_q;
   logic [31:0] store_data_q;
   logic [31:0] next_pc_q;
   logic [31:0] load_data_q;

   logic        op_legal;
   logic        is_branch;
   logic        is_load;
   logic        is_store;
   logic        is_mem;
   logic        is_link;
   logic [31:0] pc_plus4;
   logic [31:0] next_pc;
   logic        fault;

   next_pc_unit u_next_pc (
      .op        (op),
      .pc        (pc),
      .alu_out   (alu_out),
      .alu_out_b (alu_out_b),
      .op_legal  (op_legal),
      .is_branch (is_branch),
      .is_load   (is_load),
      .is_store  (is_store),
      .is_mem    (is_mem),
      .is_link   (is_link),
      .pc_plus4  (pc_plus4),
      .next_pc   (next_pc),
      .fault     (fault)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= FETCH;
         pc           <= RESET_PC;
         instr        <= '0;
         result_q     <= '0;
         store_data_q <= '0;
         next_pc_q    <= RESET_PC;
         load_data_q  <= '0;
      end else begin
         state <= state_next;
         if (state == FETCH && imem_ready) begin
            instr <= imem_rdata;
         end
         if (state == EXECUTE) begin
            result_q     <= alu_out;
            store_data_q <= reg2;
            next_pc_q    <= next_pc;
         end
         if (state == MEMORY && dmem_ready && is_load) begin
            load_data_q <= dmem_rdata;
         end
         // pc only moves on completion, so a faulting op leaves it pointing
         // at itself.
         if (state == WRITEBACK) begin
            pc <= next_pc_q;
         end
      end
   end

   always_comb begin
      state_next = state;
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      rf_we      = 1'b0;
      retire     = 1'b0;
      case (state)
         FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) state_next = DECODE;
         end
         DECODE: begin
            state_next = op_legal ? EXECUTE : HALT;
         end
         EXECUTE: begin
            if (fault)       state_next = HALT;
            else if (is_mem) state_next = MEMORY;
            else             state_next = WRITEBACK;
         end
         MEMORY: begin
            dmem_req = 1'b1;
            dmem_we  = is_store;
            if (dmem_ready) state_next = WRITEBACK;
         end
         WRITEBACK: begin
            retire     = 1'b1;
            rf_we      = ~(is_branch | is_store);
            state_next = FETCH;
         end
         HALT: begin
            state_next = HALT;
         end
         default: begin
            state_next = HALT;
         end
      endcase
      // Nothing leaves the block while reset is held, including the cycle
      // in which reset is first sampled.
      if (reset) begin
         imem_req = 1'b0;
         dmem_req = 1'b0;
         dmem_we  = 1'b0;
         rf_we    = 1'b0;
         retire   = 1'b0;
      end
   end

   always_comb begin
      if (is_link)      rf_wdata = pc_plus4;
      else if (is_load) rf_wdata = load_data_q;
      else              rf_wdata = result_q;
   end

   assign imem_addr  = pc;
   assign dmem_addr  = result_q;
   assign dmem_wdata = store_data_q;
   assign halted     = (state == HALT);
   assign state_dbg  = state;

endmodule
